// File: rtl/fdd_arb_pkg.sv
// Shared types and defaults for the FDD sector arbiter.
package fdd_arb_pkg;

    localparam int unsigned LBA_W_DEF       = 32;
    localparam logic [23:0] TIMEOUT_CYC_DEF = 24'hFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        XFER,
        DONE,
        GAP
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker; the drive named by ptr is checked first.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       valid
);

    always_comb begin
        gnt = 2'b00;
        if (ptr == 1'b0) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/fdd_sector_arbiter.sv
// Serialises D88 sector transfers of two FDD drives onto the shared hps_io sector channel,
// with round-robin fairness, ack timeout and abort on image remount.
module fdd_sector_arbiter
    import fdd_arb_pkg::*;
#(
    parameter int unsigned LBA_W       = LBA_W_DEF,
    parameter logic [23:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [1:0]         req_rd,
    input  logic [1:0]         req_wr,
    input  logic [2*LBA_W-1:0] req_lba,
    input  logic [1:0]         img_mounted,
    input  logic [1:0]         sd_ack,
    output logic [1:0]         grant,
    output logic [1:0]         req_done,
    output logic [1:0]         req_err,
    output logic [LBA_W-1:0]   sd_lba,
    output logic [1:0]         sd_rd,
    output logic [1:0]         sd_wr,
    output logic               busy
);

    state_t           state;
    logic             idx;
    logic             dir_wr;
    logic             ptr;
    logic             strobe;
    logic [1:0]       ack_q;
    logic [23:0]      cnt;
    logic [23:0]      cnt_inc;
    logic [LBA_W-1:0] lba_q;

    logic [1:0] pick_gnt;
    logic       pick_valid;
    logic       pick_idx;
    logic       ack_cur;
    logic       ack_rise;
    logic       ack_fall;
    logic       mount_hit;
    logic       timeout_hit;

    rr_pick2 u_pick (
        .req   (req_rd | req_wr),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    assign pick_idx    = pick_gnt[1];
    assign ack_cur     = sd_ack[idx];
    assign ack_rise    = ack_cur & ~ack_q[idx];
    assign ack_fall    = ~ack_cur & ack_q[idx];
    assign mount_hit   = img_mounted[idx];
    assign timeout_hit = (cnt == TIMEOUT_CYC - 24'd1);
    assign cnt_inc     = (cnt == 24'hFFFFFF) ? cnt : cnt + 24'd1;

    // Strobe is masked by the granted ack so it is never seen high together with ack.
    assign sd_rd  = (strobe && !dir_wr && !ack_cur) ? grant : 2'b00;
    assign sd_wr  = (strobe &&  dir_wr && !ack_cur) ? grant : 2'b00;
    assign sd_lba = lba_q;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 2'b00;
            req_done <= 2'b00;
            req_err  <= 2'b00;
            idx      <= 1'b0;
            dir_wr   <= 1'b0;
            ptr      <= 1'b0;
            strobe   <= 1'b0;
            ack_q    <= 2'b00;
            cnt      <= 24'd0;
            lba_q    <= '0;
        end else begin
            ack_q    <= sd_ack;
            req_done <= 2'b00;
            req_err  <= 2'b00;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        idx    <= pick_idx;
                        dir_wr <= ~req_rd[pick_idx];
                        lba_q  <= pick_idx ? req_lba[2*LBA_W-1:LBA_W] : req_lba[LBA_W-1:0];
                        grant  <= pick_gnt;
                        cnt    <= 24'd0;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt <= 24'd0;
                    if (mount_hit) begin
                        req_err <= grant;
                        grant   <= 2'b00;
                        ptr     <= ~idx;
                        state   <= GAP;
                    end else begin
                        strobe <= 1'b1;
                        state  <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_rise) begin
                        strobe <= 1'b0;
                        cnt    <= cnt_inc;
                        state  <= XFER;
                    end else if (mount_hit || timeout_hit) begin
                        strobe  <= 1'b0;
                        req_err <= grant;
                        grant   <= 2'b00;
                        ptr     <= ~idx;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                XFER: begin
                    // A completed transfer beats a coincident timeout or remount.
                    if (ack_fall) begin
                        req_done <= grant;
                        state    <= DONE;
                    end else if (mount_hit || timeout_hit) begin
                        req_err <= grant;
                        grant   <= 2'b00;
                        ptr     <= ~idx;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DONE: begin
                    grant <= 2'b00;
                    ptr   <= ~idx;
                    state <= GAP;
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdd_sector_arbiter.sv
// Directed bench for fdd_sector_arbiter with TIMEOUT_CYC shortened to 16.
module tb_fdd_sector_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [1:0]  req_rd, req_wr, img_mounted, sd_ack;
    logic [63:0] req_lba;
    logic [1:0]  grant, req_done, req_err, sd_rd, sd_wr;
    logic [31:0] sd_lba;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fdd_sector_arbiter #(
        .LBA_W       (32),
        .TIMEOUT_CYC (24'd16)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_lba     (req_lba),
        .img_mounted (img_mounted),
        .sd_ack      (sd_ack),
        .grant       (grant),
        .req_done    (req_done),
        .req_err     (req_err),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic smp;
        @(negedge clk_sys);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_rd = 2'b00; req_wr = 2'b00; img_mounted = 2'b00; sd_ack = 2'b00; req_lba = '0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_rd = 2'b00; req_wr = 2'b00; img_mounted = 2'b00; sd_ack = 2'b00; req_lba = '0;
        smp;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if ({req_done, req_err} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {req_done, req_err}); end
        checks++; if ({sd_rd, sd_wr} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {sd_rd, sd_wr}); end
        checks++; if (sd_lba !== 32'h0) begin errors++; $display("FAIL reset_lba: got %h want 0", sd_lba); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        cyc(1);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_read_basic;
        req_rd = 2'b01; req_lba = 64'h0000_0000_0000_0123;
        smp;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_grant_early: got %b want 00", grant); end
        cyc(1); smp;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rd_grant: got %b want 01", grant); end
        checks++; if (sd_rd !== 2'b00) begin errors++; $display("FAIL rd_strobe_early: got %b want 00", sd_rd); end
        checks++; if (sd_lba !== 32'h123) begin errors++; $display("FAIL rd_lba: got %h want 123", sd_lba); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy: got %b want 1", busy); end
        cyc(1); smp;
        checks++; if (sd_rd !== 2'b01) begin errors++; $display("FAIL rd_strobe: got %b want 01", sd_rd); end
        checks++; if (sd_wr !== 2'b00) begin errors++; $display("FAIL rd_no_wr: got %b want 00", sd_wr); end
        cyc(1);
        sd_ack = 2'b01;
        smp;
        checks++; if (sd_rd !== 2'b00) begin errors++; $display("FAIL rd_strobe_ack: got %b want 00", sd_rd); end
        cyc(10);
        sd_ack = 2'b00;
        smp;
        checks++; if (req_done !== 2'b00) begin errors++; $display("FAIL rd_done_early: got %b want 00", req_done); end
        checks++; if (sd_lba !== 32'h123) begin errors++; $display("FAIL rd_lba_hold: got %h want 123", sd_lba); end
        cyc(1);
        req_rd = 2'b00;
        smp;
        checks++; if (req_done !== 2'b01) begin errors++; $display("FAIL rd_done: got %b want 01", req_done); end
        cyc(1); smp;
        checks++; if (req_done !== 2'b00) begin errors++; $display("FAIL rd_done_width: got %b want 00", req_done); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_grant_release: got %b want 00", grant); end
        cyc(1); smp;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle: got %b want 0", busy); end
        cyc(1);
    endtask

    task automatic test_round_robin;
        do_reset;
        req_wr = 2'b11; req_lba = {32'h0000_00B1, 32'h0000_00A0};
        cyc(1); smp;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rr_first: got %b want 01", grant); end
        checks++; if (sd_lba !== 32'hA0) begin errors++; $display("FAIL rr_lba0: got %h want a0", sd_lba); end
        cyc(1); smp;
        checks++; if (sd_wr !== 2'b01) begin errors++; $display("FAIL rr_wr0: got %b want 01", sd_wr); end
        cyc(1); sd_ack = 2'b01; cyc(3); sd_ack = 2'b00;
        cyc(1); smp;
        checks++; if (req_done !== 2'b01) begin errors++; $display("FAIL rr_done0: got %b want 01", req_done); end
        cyc(1); smp;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_gap: got %b want 00", grant); end
        cyc(2); smp;
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rr_second: got %b want 10", grant); end
        checks++; if (sd_lba !== 32'hB1) begin errors++; $display("FAIL rr_lba1: got %h want b1", sd_lba); end
        cyc(1); smp;
        checks++; if (sd_wr !== 2'b10) begin errors++; $display("FAIL rr_wr1: got %b want 10", sd_wr); end
        cyc(1); sd_ack = 2'b10; cyc(3); sd_ack = 2'b00;
        cyc(1); smp;
        checks++; if (req_done !== 2'b10) begin errors++; $display("FAIL rr_done1: got %b want 10", req_done); end
        cyc(3); smp;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rr_third: got %b want 01", grant); end
        cyc(1); sd_ack = 2'b01; cyc(2); sd_ack = 2'b00;
        cyc(1); req_wr = 2'b00; smp;
        checks++; if (req_done !== 2'b01) begin errors++; $display("FAIL rr_done2: got %b want 01", req_done); end
        cyc(2);
    endtask

    task automatic test_timeout;
        req_rd = 2'b01; req_lba = 64'h0000_0000_0000_0077;
        cyc(1); smp;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL to_grant: got %b want 01", grant); end
        cyc(1); smp;
        checks++; if (sd_rd !== 2'b01) begin errors++; $display("FAIL to_strobe: got %b want 01", sd_rd); end
        cyc(15); smp;
        checks++; if (sd_rd !== 2'b01) begin errors++; $display("FAIL to_strobe_last: got %b want 01", sd_rd); end
        checks++; if (req_err !== 2'b00) begin errors++; $display("FAIL to_err_early: got %b want 00", req_err); end
        cyc(1);
        req_rd = 2'b00;
        smp;
        checks++; if (sd_rd !== 2'b00) begin errors++; $display("FAIL to_strobe_drop: got %b want 00", sd_rd); end
        checks++; if (req_err !== 2'b01) begin errors++; $display("FAIL to_err: got %b want 01", req_err); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to_grant_drop: got %b want 00", grant); end
        cyc(1); smp;
        checks++; if (req_err !== 2'b00) begin errors++; $display("FAIL to_err_width: got %b want 00", req_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got %b want 0", busy); end
    endtask

    task automatic test_mount_abort;
        cyc(1);
        req_rd = 2'b10; req_lba = 64'h0000_0200_0000_0000;
        cyc(1); smp;
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL mnt_grant: got %b want 10", grant); end
        checks++; if (sd_lba !== 32'h200) begin errors++; $display("FAIL mnt_lba: got %h want 200", sd_lba); end
        cyc(1); smp;
        checks++; if (sd_rd !== 2'b10) begin errors++; $display("FAIL mnt_strobe: got %b want 10", sd_rd); end
        cyc(1); sd_ack = 2'b10; cyc(2);
        img_mounted = 2'b01; cyc(1); img_mounted = 2'b00; smp;
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL mnt_other_ignored: got %b want 10", grant); end
        checks++; if (req_err !== 2'b00) begin errors++; $display("FAIL mnt_other_err: got %b want 00", req_err); end
        cyc(1); img_mounted = 2'b10; cyc(1); img_mounted = 2'b00; smp;
        checks++; if (req_err !== 2'b10) begin errors++; $display("FAIL mnt_err: got %b want 10", req_err); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL mnt_grant_drop: got %b want 00", grant); end
        checks++; if (req_done !== 2'b00) begin errors++; $display("FAIL mnt_no_done: got %b want 00", req_done); end
        cyc(1); sd_ack = 2'b00; req_rd = 2'b00; smp;
        checks++; if (req_err !== 2'b00) begin errors++; $display("FAIL mnt_err_width: got %b want 00", req_err); end
        cyc(1); smp;
        checks++; if (req_done !== 2'b00) begin errors++; $display("FAIL mnt_late_done: got %b want 00", req_done); end
        cyc(1);
    endtask

    task automatic test_stray_ack;
        req_rd = 2'b01; req_lba = 64'h0000_0000_0000_0055;
        cyc(1); smp;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL stray_grant: got %b want 01", grant); end
        cyc(1); smp;
        checks++; if (sd_rd !== 2'b01) begin errors++; $display("FAIL stray_strobe: got %b want 01", sd_rd); end
        cyc(1); sd_ack = 2'b10; smp;
        checks++; if (sd_rd !== 2'b01) begin errors++; $display("FAIL stray_strobe_held: got %b want 01", sd_rd); end
        cyc(1); smp;
        checks++; if (sd_rd !== 2'b01) begin errors++; $display("FAIL stray_no_xfer: got %b want 01", sd_rd); end
        cyc(1); sd_ack = 2'b00;
        cyc(1); sd_ack = 2'b01; cyc(2); sd_ack = 2'b00;
        cyc(1); req_rd = 2'b00; smp;
        checks++; if (req_done !== 2'b01) begin errors++; $display("FAIL stray_done: got %b want 01", req_done); end
        cyc(2); smp;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stray_idle: got %b want 0", busy); end
        cyc(1);
    endtask

    task automatic test_async_reset;
        req_rd = 2'b10; req_lba = 64'h0000_0300_0000_0000;
        cyc(1); smp;
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL arst_grant: got %b want 10", grant); end
        cyc(1); smp;
        checks++; if (sd_rd !== 2'b10) begin errors++; $display("FAIL arst_strobe: got %b want 10", sd_rd); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (sd_rd !== 2'b00) begin errors++; $display("FAIL arst_strobe_drop: got %b want 00", sd_rd); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arst_grant_drop: got %b want 00", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        req_rd = 2'b00;
        cyc(1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp;
            checks++;
            if ({req_done, req_err} !== 4'b0) begin
                errors++; $display("FAIL arst_no_pulse: got %b want 0000", {req_done, req_err});
            end
            cyc(1);
        end
    endtask

    initial begin
        test_reset;
        test_read_basic;
        test_round_robin;
        test_timeout;
        test_mount_abort;
        test_stray_ack;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
